// File: rtl/bcd_rtc_param_if.sv
// Control/load inputs and BCD time/status outputs of the BCD real-time clock.
// Signal suffixes are taken from the clock core's side (slave modport).
interface bcd_rtc_param_if;
  logic       run_i;
  logic       load_i;
  logic [5:0] ld_hour_i;
  logic [6:0] ld_min_i;
  logic [6:0] ld_sec_i;
  logic       ld_pm_i;
  logic       alm_set_i;
  logic       alm_arm_i;
  logic [3:0] sec_unit_o;
  logic [2:0] sec_ten_o;
  logic [3:0] min_unit_o;
  logic [2:0] min_ten_o;
  logic [3:0] hour_unit_o;
  logic [1:0] hour_ten_o;
  logic       pm_o;
  logic       sec_pulse_o;
  logic       load_err_o;
  logic       alarm_hit_o;

  modport slave (
    input  run_i, load_i, ld_hour_i, ld_min_i, ld_sec_i, ld_pm_i, alm_set_i, alm_arm_i,
    output sec_unit_o, sec_ten_o, min_unit_o, min_ten_o, hour_unit_o, hour_ten_o, pm_o,
    output sec_pulse_o, load_err_o, alarm_hit_o
  );

  modport master (
    output run_i, load_i, ld_hour_i, ld_min_i, ld_sec_i, ld_pm_i, alm_set_i, alm_arm_i,
    input  sec_unit_o, sec_ten_o, min_unit_o, min_ten_o, hour_unit_o, hour_ten_o, pm_o,
    input  sec_pulse_o, load_err_o, alarm_hit_o
  );
endinterface

// File: rtl/bcd_rtc_param.sv
// BCD HH:MM:SS real-time clock with 1 Hz prescaler, 24h/12h hours, validated
// time load, run/hold and a single HH:MM alarm.
module bcd_rtc_param #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          MODE_12H = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  bcd_rtc_param_if.slave bus
);

  localparam int unsigned    CntW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax     = CntW'(TICK_DIV - 1);
  localparam logic [1:0]     RstHourTen  = MODE_12H ? 2'd1 : 2'd0;
  localparam logic [3:0]     RstHourUnit = MODE_12H ? 4'd2 : 4'd0;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0] su_q, su_d, mu_q, mu_d, hu_q, hu_d;
  logic [2:0] st_q, st_d, mt_q, mt_d;
  logic [1:0] ht_q, ht_d;
  logic       pm_q, pm_d;
  logic [1:0] aht_q, aht_d;
  logic [3:0] ahu_q, ahu_d, amu_q, amu_d;
  logic [2:0] amt_q, amt_d;
  logic       apm_q, apm_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       load_err_q, load_err_d;
  logic       alarm_hit_q, alarm_hit_d;

  logic [3:0] n_su, n_mu, n_hu;
  logic [2:0] n_st, n_mt;
  logic [1:0] n_ht;
  logic       n_pm;
  logic       tick, load_ok, alm_ok, hour_v, min_v, sec_v, adv;

  function automatic logic hour_valid(input logic [5:0] h);
    logic [1:0] t;
    logic [3:0] u;
    t = h[5:4];
    u = h[3:0];
    if (MODE_12H) begin
      return ((t == 2'd0) && (u >= 4'd1) && (u <= 4'd9)) || ((t == 2'd1) && (u <= 4'd2));
    end
    return (u <= 4'd9) && ((t <= 2'd1) || ((t == 2'd2) && (u <= 4'd3)));
  endfunction

  function automatic logic sexa_valid(input logic [6:0] v);
    return (v[3:0] <= 4'd9) && (v[6:4] <= 3'd5);
  endfunction

  // Time one second after the current value; only used when a tick lands.
  always_comb begin
    n_su = su_q + 4'd1;
    n_st = st_q;
    n_mu = mu_q;
    n_mt = mt_q;
    n_hu = hu_q;
    n_ht = ht_q;
    n_pm = pm_q;
    if (su_q == 4'd9) begin
      n_su = 4'd0;
      n_st = st_q + 3'd1;
      if (st_q == 3'd5) begin
        n_st = 3'd0;
        n_mu = mu_q + 4'd1;
        if (mu_q == 4'd9) begin
          n_mu = 4'd0;
          n_mt = mt_q + 3'd1;
          if (mt_q == 3'd5) begin
            n_mt = 3'd0;
            if (MODE_12H && (ht_q == 2'd1) && (hu_q == 4'd1)) begin
              n_hu = 4'd2;
              n_pm = ~pm_q;
            end else if (MODE_12H && (ht_q == 2'd1) && (hu_q == 4'd2)) begin
              n_ht = 2'd0;
              n_hu = 4'd1;
            end else if (!MODE_12H && (ht_q == 2'd2) && (hu_q == 4'd3)) begin
              n_ht = 2'd0;
              n_hu = 4'd0;
            end else if (hu_q == 4'd9) begin
              n_ht = ht_q + 2'd1;
              n_hu = 4'd0;
            end else begin
              n_hu = hu_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    hour_v  = hour_valid(bus.ld_hour_i);
    min_v   = sexa_valid(bus.ld_min_i);
    sec_v   = sexa_valid(bus.ld_sec_i);
    tick    = bus.run_i && (cnt_q == CntMax);
    load_ok = bus.load_i && hour_v && min_v && sec_v;
    alm_ok  = bus.alm_set_i && hour_v && min_v;
    adv     = tick && !load_ok;

    cnt_d = cnt_q;
    if (load_ok || tick) begin
      cnt_d = '0;
    end else if (bus.run_i) begin
      cnt_d = cnt_q + CntW'(1);
    end

    {ht_d, hu_d, mt_d, mu_d, st_d, su_d, pm_d} = {ht_q, hu_q, mt_q, mu_q, st_q, su_q, pm_q};
    if (load_ok) begin
      {ht_d, hu_d} = bus.ld_hour_i;
      {mt_d, mu_d} = bus.ld_min_i;
      {st_d, su_d} = bus.ld_sec_i;
      pm_d         = MODE_12H ? bus.ld_pm_i : 1'b0;
    end else if (tick) begin
      {ht_d, hu_d, mt_d, mu_d, st_d, su_d, pm_d} = {n_ht, n_hu, n_mt, n_mu, n_st, n_su, n_pm};
    end

    {aht_d, ahu_d, amt_d, amu_d, apm_d} = {aht_q, ahu_q, amt_q, amu_q, apm_q};
    if (alm_ok) begin
      {aht_d, ahu_d} = bus.ld_hour_i;
      {amt_d, amu_d} = bus.ld_min_i;
      apm_d          = MODE_12H ? bus.ld_pm_i : 1'b0;
    end

    sec_pulse_d = adv;
    load_err_d  = (bus.load_i && !load_ok) || (bus.alm_set_i && !alm_ok);
    alarm_hit_d = adv && bus.alm_arm_i && (n_ht == aht_q) && (n_hu == ahu_q) &&
                  (n_mt == amt_q) && (n_mu == amu_q) && (n_st == 3'd0) && (n_su == 4'd0) &&
                  (!MODE_12H || (n_pm == apm_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      su_q        <= 4'd0;
      st_q        <= 3'd0;
      mu_q        <= 4'd0;
      mt_q        <= 3'd0;
      hu_q        <= RstHourUnit;
      ht_q        <= RstHourTen;
      pm_q        <= 1'b0;
      ahu_q       <= RstHourUnit;
      aht_q       <= RstHourTen;
      amu_q       <= 4'd0;
      amt_q       <= 3'd0;
      apm_q       <= 1'b0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      su_q        <= su_d;
      st_q        <= st_d;
      mu_q        <= mu_d;
      mt_q        <= mt_d;
      hu_q        <= hu_d;
      ht_q        <= ht_d;
      pm_q        <= pm_d;
      ahu_q       <= ahu_d;
      aht_q       <= aht_d;
      amu_q       <= amu_d;
      amt_q       <= amt_d;
      apm_q       <= apm_d;
      sec_pulse_q <= sec_pulse_d;
      load_err_q  <= load_err_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign bus.sec_unit_o  = su_q;
  assign bus.sec_ten_o   = st_q;
  assign bus.min_unit_o  = mu_q;
  assign bus.min_ten_o   = mt_q;
  assign bus.hour_unit_o = hu_q;
  assign bus.hour_ten_o  = ht_q;
  assign bus.pm_o        = pm_q;
  assign bus.sec_pulse_o = sec_pulse_q;
  assign bus.load_err_o  = load_err_q;
  assign bus.alarm_hit_o = alarm_hit_q;

endmodule

// File: tb/tb_bcd_rtc_param.sv
// Directed bench: one 24h and one 12h clock instance, both with TICK_DIV=4.
module tb_bcd_rtc_param;
  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  bcd_rtc_param_if b24 ();
  bcd_rtc_param_if b12 ();

  bcd_rtc_param #(.TICK_DIV(4), .MODE_12H(1'b0)) dut24 (.clk(clk), .reset(reset), .bus(b24.slave));
  bcd_rtc_param #(.TICK_DIV(4), .MODE_12H(1'b1)) dut12 (.clk(clk), .reset(reset), .bus(b12.slave));

  // Time as 0xHHMMSS for readable comparisons.
  logic [23:0] t24, t12;
  assign t24 = {2'b0, b24.hour_ten_o, b24.hour_unit_o, 1'b0, b24.min_ten_o, b24.min_unit_o,
                1'b0, b24.sec_ten_o, b24.sec_unit_o};
  assign t12 = {2'b0, b12.hour_ten_o, b12.hour_unit_o, 1'b0, b12.min_ten_o, b12.min_unit_o,
                1'b0, b12.sec_ten_o, b12.sec_unit_o};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load24(input logic [23:0] v);
    b24.ld_hour_i = v[21:16];
    b24.ld_min_i  = v[14:8];
    b24.ld_sec_i  = v[6:0];
    b24.load_i    = 1'b1;
    step(1);
    b24.load_i    = 1'b0;
  endtask

  task automatic load12(input logic [23:0] v, input logic p);
    b12.ld_hour_i = v[21:16];
    b12.ld_min_i  = v[14:8];
    b12.ld_sec_i  = v[6:0];
    b12.ld_pm_i   = p;
    b12.load_i    = 1'b1;
    step(1);
    b12.load_i    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    vecs++; if (t24 !== 24'h000000) begin errs++; $display("FAIL rst24_time got %h want 000000", t24); end
    vecs++; if (t12 !== 24'h120000) begin errs++; $display("FAIL rst12_time got %h want 120000", t12); end
    vecs++; if (b12.pm_o !== 1'b0) begin errs++; $display("FAIL rst12_pm got %b want 0", b12.pm_o); end
    vecs++;
    if ({b24.sec_pulse_o, b24.load_err_o, b24.alarm_hit_o} !== 3'b000) begin
      errs++; $display("FAIL rst_pulses got %b want 000", {b24.sec_pulse_o, b24.load_err_o, b24.alarm_hit_o});
    end
  endtask

  task automatic test_prescaler();
    reset = 1'b0;
    b24.run_i = 1'b1;
    b12.run_i = 1'b1;
    step(3);
    vecs++; if (b24.sec_pulse_o !== 1'b0 || t24 !== 24'h0) begin errs++; $display("FAIL presc_early got pulse=%b t=%h want 0/000000", b24.sec_pulse_o, t24); end
    step(1);
    vecs++; if (b24.sec_pulse_o !== 1'b1) begin errs++; $display("FAIL presc_pulse got %b want 1", b24.sec_pulse_o); end
    vecs++; if (t24 !== 24'h000001) begin errs++; $display("FAIL presc_t24 got %h want 000001", t24); end
    vecs++; if (t12 !== 24'h120001) begin errs++; $display("FAIL presc_t12 got %h want 120001", t12); end
    step(1);
    vecs++; if (b24.sec_pulse_o !== 1'b0) begin errs++; $display("FAIL presc_pulse_len got %b want 0", b24.sec_pulse_o); end
    step(1);
    #2 reset = 1'b1;
    #1;
    vecs++; if (t24 !== 24'h000000) begin errs++; $display("FAIL async_rst got %h want 000000", t24); end
    #1 reset = 1'b0;
    step(3);
    vecs++; if (b24.sec_pulse_o !== 1'b0 || t24 !== 24'h0) begin errs++; $display("FAIL rst_presc_clear got pulse=%b t=%h want 0/000000", b24.sec_pulse_o, t24); end
    step(1);
    vecs++; if (b24.sec_pulse_o !== 1'b1 || t24 !== 24'h000001) begin errs++; $display("FAIL rst_presc_tick got pulse=%b t=%h want 1/000001", b24.sec_pulse_o, t24); end
    b24.run_i = 1'b0;
    b12.run_i = 1'b0;
    step(1);
  endtask

  task automatic test_rollover_24h();
    logic [23:0] ld [5] = '{24'h235959, 24'h095959, 24'h195959, 24'h125959, 24'h000959};
    logic [23:0] ex [5] = '{24'h000000, 24'h100000, 24'h200000, 24'h130000, 24'h001000};
    for (int i = 0; i < 5; i++) begin
      load24(ld[i]);
      vecs++; if (t24 !== ld[i] || b24.load_err_o !== 1'b0) begin errs++; $display("FAIL r24_load%0d got %h err=%b want %h err=0", i, t24, b24.load_err_o, ld[i]); end
      b24.run_i = 1'b1;
      step(4);
      vecs++; if (t24 !== ex[i]) begin errs++; $display("FAIL r24_tick%0d got %h want %h", i, t24, ex[i]); end
      vecs++; if (b24.sec_pulse_o !== 1'b1 || b24.load_err_o !== 1'b0) begin errs++; $display("FAIL r24_flags%0d got pulse=%b err=%b want 1/0", i, b24.sec_pulse_o, b24.load_err_o); end
      b24.run_i = 1'b0;
    end
  endtask

  task automatic test_rollover_12h();
    logic [23:0] ld [4] = '{24'h115959, 24'h125959, 24'h115959, 24'h095959};
    logic        pi [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [23:0] ex [4] = '{24'h120000, 24'h010000, 24'h120000, 24'h100000};
    logic        pe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      load12(ld[i], pi[i]);
      b12.run_i = 1'b1;
      step(4);
      vecs++; if (t12 !== ex[i] || b12.pm_o !== pe[i]) begin errs++; $display("FAIL r12_tick%0d got %h pm=%b want %h pm=%b", i, t12, b12.pm_o, ex[i], pe[i]); end
      b12.run_i = 1'b0;
    end
  endtask

  task automatic test_invalid_load();
    logic [23:0] bad24 [3] = '{24'h245959, 24'h106000, 24'h10000A};
    logic [23:0] bad12 [2] = '{24'h000000, 24'h130000};
    load24(24'h050607);
    for (int i = 0; i < 3; i++) begin
      load24(bad24[i]);
      vecs++; if (b24.load_err_o !== 1'b1 || t24 !== 24'h050607) begin errs++; $display("FAIL inv24_%0d got err=%b t=%h want 1/050607", i, b24.load_err_o, t24); end
      step(1);
      vecs++; if (b24.load_err_o !== 1'b0) begin errs++; $display("FAIL inv24_len%0d got %b want 0", i, b24.load_err_o); end
    end
    load12(24'h050607, 1'b1);
    for (int i = 0; i < 2; i++) begin
      load12(bad12[i], 1'b0);
      vecs++; if (b12.load_err_o !== 1'b1 || t12 !== 24'h050607 || b12.pm_o !== 1'b1) begin errs++; $display("FAIL inv12_%0d got err=%b t=%h pm=%b want 1/050607/1", i, b12.load_err_o, t12, b12.pm_o); end
    end
    b24.ld_hour_i = 6'h2A;
    b24.ld_min_i  = 7'h00;
    b24.alm_set_i = 1'b1;
    step(1);
    b24.alm_set_i = 1'b0;
    vecs++; if (b24.load_err_o !== 1'b1) begin errs++; $display("FAIL inv_alm got %b want 1", b24.load_err_o); end
  endtask

  task automatic test_alarm();
    b24.ld_hour_i = 6'h07;
    b24.ld_min_i  = 7'h30;
    b24.alm_set_i = 1'b1;
    step(1);
    b24.alm_set_i = 1'b0;
    vecs++; if (b24.load_err_o !== 1'b0) begin errs++; $display("FAIL alm_set_err got %b want 0", b24.load_err_o); end
    b24.alm_arm_i = 1'b1;
    load24(24'h072959);
    b24.run_i = 1'b1;
    step(3);
    vecs++; if (b24.alarm_hit_o !== 1'b0) begin errs++; $display("FAIL alm_early got %b want 0", b24.alarm_hit_o); end
    step(1);
    vecs++; if (b24.alarm_hit_o !== 1'b1 || t24 !== 24'h073000) begin errs++; $display("FAIL alm_hit got %b t=%h want 1/073000", b24.alarm_hit_o, t24); end
    step(1);
    vecs++; if (b24.alarm_hit_o !== 1'b0) begin errs++; $display("FAIL alm_len got %b want 0", b24.alarm_hit_o); end
    b24.run_i = 1'b0;
    b24.alm_arm_i = 1'b0;
    load24(24'h072959);
    b24.run_i = 1'b1;
    step(4);
    vecs++; if (b24.alarm_hit_o !== 1'b0 || t24 !== 24'h073000) begin errs++; $display("FAIL alm_disarm got %b t=%h want 0/073000", b24.alarm_hit_o, t24); end
    b24.run_i = 1'b0;
    b24.alm_arm_i = 1'b1;
    load24(24'h073000);
    vecs++; if (b24.alarm_hit_o !== 1'b0) begin errs++; $display("FAIL alm_on_load got %b want 0", b24.alarm_hit_o); end
    b24.run_i = 1'b1;
    step(4);
    vecs++; if (b24.alarm_hit_o !== 1'b0 || t24 !== 24'h073001) begin errs++; $display("FAIL alm_after_load got %b t=%h want 0/073001", b24.alarm_hit_o, t24); end
    b24.run_i = 1'b0;
    b24.alm_arm_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    b24.run_i = 1'b1;
    load24(24'h010203);
    step(3);
    load24(24'h102030);
    vecs++; if (t24 !== 24'h102030 || b24.sec_pulse_o !== 1'b0) begin errs++; $display("FAIL coinc_load got %h pulse=%b want 102030/0", t24, b24.sec_pulse_o); end
    step(3);
    vecs++; if (t24 !== 24'h102030 || b24.sec_pulse_o !== 1'b0) begin errs++; $display("FAIL coinc_restart got %h pulse=%b want 102030/0", t24, b24.sec_pulse_o); end
    step(1);
    vecs++; if (t24 !== 24'h102031 || b24.sec_pulse_o !== 1'b1) begin errs++; $display("FAIL coinc_tick got %h pulse=%b want 102031/1", t24, b24.sec_pulse_o); end
    step(2);
    b24.run_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (b24.sec_pulse_o === 1'b1) pulses++;
    end
    vecs++; if (pulses != 0 || t24 !== 24'h102031) begin errs++; $display("FAIL hold got pulses=%0d t=%h want 0/102031", pulses, t24); end
    b24.run_i = 1'b1;
    step(1);
    vecs++; if (b24.sec_pulse_o !== 1'b0) begin errs++; $display("FAIL resume_early got %b want 0", b24.sec_pulse_o); end
    step(1);
    vecs++; if (b24.sec_pulse_o !== 1'b1 || t24 !== 24'h102032) begin errs++; $display("FAIL resume_tick got pulse=%b t=%h want 1/102032", b24.sec_pulse_o, t24); end
    b24.run_i = 1'b0;
  endtask

  initial begin
    {b24.run_i, b24.load_i, b24.ld_pm_i, b24.alm_set_i, b24.alm_arm_i} = '0;
    {b12.run_i, b12.load_i, b12.ld_pm_i, b12.alm_set_i, b12.alm_arm_i} = '0;
    {b24.ld_hour_i, b24.ld_min_i, b24.ld_sec_i} = '0;
    {b12.ld_hour_i, b12.ld_min_i, b12.ld_sec_i} = '0;
    test_reset();
    test_prescaler();
    test_rollover_24h();
    test_rollover_12h();
    test_invalid_load();
    test_alarm();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
